// File: rtl/regfile_dump_pkg.sv
// Shared constants for the register-file dump engine: default widths and FSM state encoding.
package regfile_dump_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks a register-file read port from first_addr to last_addr (inclusive) and streams
// each register out as a valid/ready beat, accumulating a wrapping checksum.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, abort             begin a dump (IDLE only) / cancel a dump in progress
//   first_addr, last_addr    inclusive index range, sampled with start
//   ra, rd                   register-file asynchronous read port
//   out_valid/out_ready      beat handshake; out_addr/out_data carry the beat
//   busy, done, checksum     status: not-IDLE, completion pulse, sum of accepted beats
module regfile_dump #(
   parameter int unsigned XLEN = regfile_dump_pkg::XLEN,
   parameter int unsigned AW   = regfile_dump_pkg::AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [AW-1:0]   first_addr,
   input  logic [AW-1:0]   last_addr,
   output logic [AW-1:0]   ra,
   input  logic [XLEN-1:0] rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [AW-1:0]   out_addr,
   output logic [XLEN-1:0] out_data,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] checksum
);

   import regfile_dump_pkg::*;

   state_t        state;
   logic [AW-1:0] addr;
   logic [AW-1:0] last_q;

   // Read address comes straight from a flop so the register file sees no glitches.
   assign ra = addr;

   // Dump sequencer with registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         addr      <= '0;
         last_q    <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         checksum  <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         done <= 1'b0;
         // Abort beats everything else, including a beat accepted in the same cycle.
         if (abort && (state != IDLE)) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     checksum <= '0;
                     busy     <= 1'b1;
                     if (first_addr <= last_addr) begin
                        last_q <= last_addr;
                        addr   <= first_addr;
                        state  <= READ;
                     end else begin
                        // Empty range: complete immediately with no beats.
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  end
               end
               READ: begin
                  out_data  <= rd;
                  out_addr  <= addr;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
               HOLD: begin
                  if (out_ready) begin
                     checksum  <= checksum + out_data;
                     out_valid <= 1'b0;
                     // Compare before incrementing so last_addr at the top index never wraps.
                     if (addr == last_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        addr  <= addr + AW'(1);
                        state <= READ;
                     end
                  end
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: expected beats are queued at start, a negedge monitor
// pops them on every accepted beat, and per-dump status (done, checksum) is checked at the end.
module tb_regfile_dump;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [AW-1:0]   first_addr = '0;
   logic [AW-1:0]   last_addr = '0;
   logic [AW-1:0]   ra;
   logic [XLEN-1:0] rd;
   logic            out_valid;
   logic            out_ready;
   logic [AW-1:0]   out_addr;
   logic [XLEN-1:0] out_data;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] checksum;

   logic force_stall = 1'b0;
   logic rand_mode   = 1'b0;
   logic rnd_bit     = 1'b1;

   logic [XLEN-1:0] regs [32];

   typedef struct packed {
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
   } beat_t;

   beat_t exp_q [$];
   int    n_cmp    = 0;
   int    n_bad    = 0;
   int    done_cnt = 0;

   regfile_dump dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .ra         (ra),
      .rd         (rd),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .busy       (busy),
      .done       (done),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   // Register file: index 0 is hardwired to zero.
   assign rd        = (ra == '0) ? '0 : regs[ra];
   assign out_ready = !force_stall && (!rand_mode || rnd_bit);

   always begin
      @(posedge clk);
      #1 rnd_bit = ($urandom_range(0, 2) != 0);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event not observed", name);
   endtask

   function automatic logic [XLEN-1:0] model_rd(input int i);
      return (i == 0) ? '0 : regs[i];
   endfunction

   function automatic logic [XLEN-1:0] model_sum(input int f, input int l);
      logic [XLEN-1:0] s;
      s = '0;
      for (int i = f; i <= l; i++) s = s + model_rd(i);
      return s;
   endfunction

   // Monitor: scoreboard pops on accepted beats, stall stability, done counting.
   logic            hold_prev = 1'b0;
   logic [AW-1:0]   prev_a;
   logic [XLEN-1:0] prev_d;
   beat_t           mon_e;

   always @(negedge clk) begin
      if (!rst) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_addr", 64'(out_addr), 64'(prev_a));
            check("hold_data", 64'(out_data), 64'(prev_d));
         end
         if (done) done_cnt++;
         if (out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
               fail("unexpected_beat");
            end else begin
               mon_e = exp_q.pop_front();
               check("beat_addr", 64'(out_addr), 64'(mon_e.a));
               check("beat_data", 64'(out_data), 64'(mon_e.d));
            end
         end
         hold_prev = out_valid && !out_ready && !abort;
         prev_a    = out_addr;
         prev_d    = out_data;
      end
   end

   // Queue the expected beats and pulse start; returns 1ns after the accepting edge.
   task automatic start_dump(input int f, input int l);
      beat_t b;
      for (int i = f; i <= l; i++) begin
         b.a = AW'(i);
         b.d = model_rd(i);
         exp_q.push_back(b);
      end
      @(posedge clk);
      #1;
      first_addr = AW'(f);
      last_addr  = AW'(l);
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Wait for done, then check completion status; exp_cycles <= 0 skips latency checks.
   task automatic finish_dump(input int f, input int l, input int d0, input int exp_cycles);
      int cyc;
      int fv;
      bit seen;
      cyc  = 0;
      fv   = 0;
      seen = 1'b0;
      for (int c = 1; c <= 3000; c++) begin
         @(negedge clk);
         if (out_valid && fv == 0) fv = c;
         if (done) begin
            seen = 1'b1;
            cyc  = c;
            break;
         end
      end
      if (!seen) begin
         fail("done_timeout");
      end else begin
         if (exp_cycles > 0) begin
            check("done_latency", 64'(cyc), 64'(exp_cycles));
            if (f <= l) check("first_valid_latency", 64'(fv), 64'(2));
         end
         if (f > l) check("no_beat_on_empty", 64'(fv), 64'(0));
      end
      @(negedge clk);
      check("done_pulses", 64'(done_cnt - d0), 64'(1));
      check("done_width", 64'(done), 64'(0));
      check("busy_idle", 64'(busy), 64'(0));
      check("checksum", 64'(checksum), 64'(model_sum(f, l)));
      check("queue_empty", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int  d0;
      int  f;
      int  l;
      bit  found;

      for (int i = 0; i < 32; i++) regs[i] = XLEN'(i * 32'h11);

      // Reset state.
      #3;
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_checksum", 64'(checksum), 64'(0));
      check("rst_ra", 64'(ra), 64'(0));
      check("rst_out_addr", 64'(out_addr), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      #9 rst = 1'b1;

      // Full sweep 1..31 at full throughput.
      d0 = done_cnt;
      start_dump(1, 31);
      finish_dump(1, 31, d0, 63);

      // Single beat at index 0.
      d0 = done_cnt;
      start_dump(0, 0);
      finish_dump(0, 0, d0, 3);

      // Empty range.
      d0 = done_cnt;
      start_dump(5, 3);
      finish_dump(5, 3, d0, 1);

      // Stall five cycles on beat 2.
      d0 = done_cnt;
      start_dump(1, 4);
      repeat (2) @(posedge clk);
      #1 force_stall = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_addr", 64'(out_addr), 64'(2));
      check("stall_data", 64'(out_data), 64'(model_rd(2)));
      repeat (3) @(posedge clk);
      #1 force_stall = 1'b0;
      finish_dump(1, 4, d0, -1);

      // Ignored start while busy, then abort on beat 3 with out_ready high.
      d0 = done_cnt;
      start_dump(1, 31);
      found = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         if (out_valid && out_addr == AW'(2)) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) fail("beat2_wait");
      start      = 1'b1;
      first_addr = '0;
      last_addr  = '0;
      @(posedge clk);
      #1 start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (out_valid && out_addr == AW'(3)) begin
            found = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!found) fail("beat3_wait");
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_valid", 64'(out_valid), 64'(0));
      check("abort_checksum", 64'(checksum), 64'(model_sum(1, 2)));
      check("abort_beats_left", 64'(exp_q.size()), 64'(29));
      exp_q.delete();
      repeat (5) @(negedge clk);
      check("abort_no_done", 64'(done_cnt - d0), 64'(0));
      check("abort_stays_idle", 64'(busy), 64'(0));
      check("abort_checksum_frozen", 64'(checksum), 64'(model_sum(1, 2)));

      // Asynchronous reset mid-dump, then a clean full sweep.
      d0 = done_cnt;
      start_dump(1, 31);
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid), 64'(0));
      check("arst_busy", 64'(busy), 64'(0));
      check("arst_done", 64'(done), 64'(0));
      check("arst_checksum", 64'(checksum), 64'(0));
      check("arst_ra", 64'(ra), 64'(0));
      check("arst_out_addr", 64'(out_addr), 64'(0));
      check("arst_out_data", 64'(out_data), 64'(0));
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("arst_idle", 64'(busy), 64'(0));
      check("arst_no_done", 64'(done_cnt - d0), 64'(0));
      d0 = done_cnt;
      start_dump(1, 31);
      finish_dump(1, 31, d0, 63);

      // Random contents, ranges and backpressure.
      rand_mode = 1'b1;
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 32; i++) regs[i] = $urandom;
         f = int'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) l = int'($urandom_range(0, 31));
         else l = int'($urandom_range(f, 31));
         d0 = done_cnt;
         start_dump(f, l);
         finish_dump(f, l, d0, -1);
      end
      rand_mode = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
